uart2wifi_core_tx_arbiter: RTL
==============================

Name: uart2wifi_core_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmitter between two byte sources. Source 0 is the host-data FIFO; source 1 is the status/command FIFO. The block pops one byte at a time from the granted FIFO, issues it to uart2wifi_core_uart with a one-cycle tx_wr pulse, and tracks the UART busy handshake. It enforces a per-source burst limit and an optional inter-byte gap, and keeps per-source sent counters and a sticky handshake-timeout flag.

Parameters:
DATA_WIDTH, 8, byte width of source and UART data
MAX_BURST, 4, max consecutive bytes from one source while the other is non-empty (>=1)
GAP_CYCLES, 0, idle clocks inserted after each byte completes (0 = none)
ACK_TIMEOUT, 8, clocks to wait for tx_busy to rise after tx_wr
CNT_WIDTH, 16, width of sent counters

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset; asynchronous, active-low (asserted at 0)
enable  in  1  permits new bytes to start
src0_empty  in  1  source 0 FIFO empty
src0_data  in  DATA_WIDTH  source 0 FIFO head (show-ahead)
src0_rd  out  1  source 0 pop pulse
src1_empty  in  1  source 1 FIFO empty
src1_data  in  DATA_WIDTH  source 1 FIFO head (show-ahead)
src1_rd  out  1  source 1 pop pulse
tx_wr  out  1  UART write strobe, one cycle
tx_data  out  DATA_WIDTH  byte to UART; registered, holds last byte
tx_busy  in  1  UART transmitting
grant  out  2  one-hot owner of the current byte; 00 when idle
sent_count0  out  CNT_WIDTH  bytes sent from source 0, wraps
sent_count1  out  CNT_WIDTH  bytes sent from source 1, wraps
err_timeout  out  1  sticky; tx_busy failed to rise within ACK_TIMEOUT
clr_err  in  1  clears err_timeout

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; burst count 0; last-served = source 1, so source 0 wins first.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: when enable=1 and at least one source is non-empty, select a source and go to SEND at the next edge. Latch the selected srcX_data into tx_data and set grant.
- Selection rule:
  - Owner keeps the grant if it is non-empty and burst count < MAX_BURST.
  - Otherwise, pick the source not last served if it is non-empty, else the other source.
  - Switching source resets burst count to 0.
  - Owner going empty ends its burst.
- SEND (exactly 1 cycle): tx_wr=1 and srcX_rd=1 for the granted source. Increment that source's sent_count and burst count. Go to WAIT_BUSY.
- Latency: source non-empty sampled in IDLE -> tx_wr high on the following cycle.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - After ACK_TIMEOUT cycles without busy: set err_timeout and go to GAP/IDLE; the byte still counts as sent.
- WAIT_DONE: tx_busy=0 -> GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES clocks, then IDLE.
- Next-byte timing: tx_wr rises GAP_CYCLES+1 edges after the edge at which tx_busy is first sampled low.
- grant returns to 00 in IDLE while nothing is selected. tx_data is never cleared except by reset.
- enable=0 mid-byte: the current byte completes through all states; no new SEND until enable=1.
- srcX_rd is never asserted while srcX_empty=1. At most one rd is high per cycle.
- err_timeout: set has priority over clr_err in the same cycle.
- Counters wrap modulo 2^CNT_WIDTH with no flag.

Test Plan:
- src0 holds 0x77,0x86,0xFA; src1 empty; UART model busy 10 cycles after each tx_wr -> 3 tx_wr pulses with tx_data 0x77,0x86,0xFA in order; 3 src0_rd pulses; sent_count0=3; sent_count1=0; grant=01 during each byte.
- Both sources hold 6 bytes, MAX_BURST=4 -> service order src0×4, src1×4, src0×2, src1×2; final sent_count0=6, sent_count1=6.
- tx_busy tied 0, ACK_TIMEOUT=8 -> err_timeout=1 eight cycles after tx_wr; next byte still issued; clr_err=1 for one cycle -> err_timeout=0.
- GAP_CYCLES=3; tx_busy falls at edge E -> next tx_wr high in the cycle after edge E+4; with GAP_CYCLES=0 it is high after edge E+1.
- enable dropped during WAIT_DONE with src0 non-empty -> current byte finishes; no tx_wr for 50 cycles; enable=1 -> tx_wr the next-but-one cycle.
- rst pulsed low in WAIT_DONE -> tx_wr, tx_data, grant, counters and err_timeout read 0 immediately; after release with both sources non-empty, the first grant is 01.

Source files
------------

// File: rtl/uart2wifi_core_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart2wifi_core_tx_arbiter
//
// Round-robin scheduler that shares one UART transmitter between two byte
// sources (source 0 = host-data FIFO, source 1 = status/command FIFO). One byte
// at a time is popped from the granted FIFO, handed to the UART with a
// single-cycle tx_wr strobe, and tracked through the UART busy handshake.
// A per-source burst limit, an optional inter-byte gap, per-source sent
// counters and a sticky handshake-timeout flag are provided.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   enable       permits new bytes to start
//   src0_empty   source 0 FIFO empty
//   src0_data    source 0 FIFO head (show-ahead)
//   src0_rd      source 0 pop pulse
//   src1_empty   source 1 FIFO empty
//   src1_data    source 1 FIFO head (show-ahead)
//   src1_rd      source 1 pop pulse
//   tx_wr        UART write strobe, one cycle
//   tx_data      byte to UART, holds the last byte issued
//   tx_busy      UART transmitting
//   grant        one-hot owner of the current byte, 00 when idle
//   sent_count0  bytes sent from source 0 (wraps)
//   sent_count1  bytes sent from source 1 (wraps)
//   err_timeout  sticky: tx_busy did not rise within ACK_TIMEOUT clocks
//   clr_err      clears err_timeout (a new timeout wins over the clear)
// -----------------------------------------------------------------------------
module uart2wifi_core_tx_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int ACK_TIMEOUT = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  src0_empty,
    input  logic [DATA_WIDTH-1:0] src0_data,
    output logic                  src0_rd,
    input  logic                  src1_empty,
    input  logic [DATA_WIDTH-1:0] src1_data,
    output logic                  src1_rd,
    output logic                  tx_wr,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  sent_count0,
    output logic [CNT_WIDTH-1:0]  sent_count1,
    output logic                  err_timeout,
    input  logic                  clr_err
);

    // Counter widths; every counter is at least one bit wide so GAP_CYCLES=0
    // still elaborates cleanly.
    localparam int BURST_W = (MAX_BURST   > 1) ? $clog2(MAX_BURST + 1)   : 1;
    localparam int TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int GAP_W   = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES + 1)  : 1;

    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]    TO_ONE     = TO_W'(1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;

    logic                   last_r;       // last source served (owner of the burst)
    logic [BURST_W-1:0]     burst_r;      // bytes sent by last_r in the current burst
    logic [TO_W-1:0]        wait_cnt_r;
    logic [GAP_W-1:0]       gap_cnt_r;

    logic                   tx_wr_r;
    logic                   src0_rd_r;
    logic                   src1_rd_r;
    logic [1:0]             grant_r;
    logic [DATA_WIDTH-1:0]  tx_data_r;
    logic [CNT_WIDTH-1:0]   cnt0_r;
    logic [CNT_WIDTH-1:0]   cnt1_r;
    logic                   err_r;

    logic                   owner_ne_s;
    logic                   other_ne_s;
    logic                   sel_valid_s;
    logic                   sel_src_s;
    logic                   start_s;
    logic                   timeout_hit_s;
    logic                   gap_done_s;
    state_t                 done_next_s;

    // Source selection: the owner keeps the grant only inside an active burst
    // (burst_r != 0) that has not hit the limit; otherwise the other source is
    // preferred, falling back to the owner when the other is empty.
    always_comb begin
        owner_ne_s  = last_r ? ~src1_empty : ~src0_empty;
        other_ne_s  = last_r ? ~src0_empty : ~src1_empty;
        sel_valid_s = 1'b0;
        sel_src_s   = last_r;
        if (owner_ne_s && (burst_r != '0) && (burst_r < BURST_MAX)) begin
            sel_valid_s = 1'b1;
            sel_src_s   = last_r;
        end else if (other_ne_s) begin
            sel_valid_s = 1'b1;
            sel_src_s   = ~last_r;
        end else if (owner_ne_s) begin
            sel_valid_s = 1'b1;
            sel_src_s   = last_r;
        end else begin
            sel_valid_s = 1'b0;
            sel_src_s   = last_r;
        end
    end

    // Handshake condition decode and the state that follows a completed byte.
    always_comb begin
        start_s       = (state_r == ST_IDLE) && enable && sel_valid_s;
        timeout_hit_s = (state_r == ST_WAIT_BUSY) && ~tx_busy && (wait_cnt_r == TO_LAST);
        gap_done_s    = (gap_cnt_r == GAP_LAST);
        if (GAP_CYCLES > 0) begin
            done_next_s = ST_GAP;
        end else begin
            done_next_s = ST_IDLE;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                next_state_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    next_state_s = ST_WAIT_DONE;
                end else if (timeout_hit_s) begin
                    next_state_s = done_next_s;
                end else begin
                    next_state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    next_state_s = done_next_s;
                end else begin
                    next_state_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Handshake timeout and inter-byte gap counters, cleared outside their state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= '0;
            gap_cnt_r  <= '0;
        end else begin
            if (state_r == ST_WAIT_BUSY) begin
                wait_cnt_r <= wait_cnt_r + TO_ONE;
            end else begin
                wait_cnt_r <= '0;
            end
            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GAP_ONE;
            end else begin
                gap_cnt_r <= '0;
            end
        end
    end

    // Strobes, grant and data latch; the strobes are registered from start_s
    // so they are high exactly while the FSM sits in SEND.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_r   <= 1'b0;
            src0_rd_r <= 1'b0;
            src1_rd_r <= 1'b0;
            grant_r   <= 2'b00;
            tx_data_r <= '0;
        end else begin
            tx_wr_r   <= start_s;
            src0_rd_r <= start_s & ~sel_src_s;
            src1_rd_r <= start_s &  sel_src_s;
            if (start_s) begin
                grant_r   <= sel_src_s ? 2'b10 : 2'b01;
                tx_data_r <= sel_src_s ? src1_data : src0_data;
            end else if (next_state_s == ST_IDLE) begin
                grant_r   <= 2'b00;
            end else begin
                grant_r   <= grant_r;
            end
        end
    end

    // Round-robin bookkeeping: last served source and its burst length.
    // Reset makes source 1 the last served so source 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r  <= 1'b1;
            burst_r <= '0;
        end else begin
            if (start_s) begin
                last_r <= sel_src_s;
            end else begin
                last_r <= last_r;
            end
            if (state_r == ST_SEND) begin
                if (burst_r < BURST_MAX) begin
                    burst_r <= burst_r + BURST_ONE;
                end else begin
                    burst_r <= burst_r;
                end
            end else if (start_s && (sel_src_s != last_r)) begin
                burst_r <= '0;
            end else if ((state_r == ST_IDLE) && !owner_ne_s) begin
                // owner ran dry: its burst is over
                burst_r <= '0;
            end else begin
                burst_r <= burst_r;
            end
        end
    end

    // Per-source sent counters, bumped in SEND; a timed-out byte still counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_r <= '0;
            cnt1_r <= '0;
        end else begin
            if ((state_r == ST_SEND) && grant_r[0]) begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end else begin
                cnt0_r <= cnt0_r;
            end
            if ((state_r == ST_SEND) && grant_r[1]) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end else begin
                cnt1_r <= cnt1_r;
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (timeout_hit_s) begin
            err_r <= 1'b1;
        end else if (clr_err) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign tx_wr       = tx_wr_r;
    assign src0_rd     = src0_rd_r;
    assign src1_rd     = src1_rd_r;
    assign grant       = grant_r;
    assign tx_data     = tx_data_r;
    assign sent_count0 = cnt0_r;
    assign sent_count1 = cnt1_r;
    assign err_timeout = err_r;

endmodule
